// File: rtl/my_uart_rx16.sv
// 16x oversampling UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1.
// Bits are decided by a 3-sample majority vote at samples 7, 8 and 9 of each bit.
module my_uart_rx16 #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rs232_rx,
  output logic [7:0] rx_data,
  output logic       rx_int,
  output logic       rx_done,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int DIV   = CLK_FREQ / (BAUD * 16);
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;
`endif

  state_t           state_q;
  logic             rx_meta_q;
  logic             rx_sync_q;
  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;
  logic [3:0]       smp_q;
  logic [3:0]       smp_d;
  logic             s7_q;
  logic             s8_q;
  logic [2:0]       idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       rx_data_q;
  logic             rx_int_q;
  logic             rx_done_q;
  logic             frame_err_q;
  logic             tick;
  logic             decide;
  logic             wrap;
  logic             maj;

  // Prescaler/sample-counter next state and the majority decision point.
  always_comb begin
    tick   = (pre_q == PRE_MAX);
    decide = tick && (smp_q == 4'd9);
    wrap   = tick && (smp_q == 4'd15);
    maj    = (s7_q & s8_q) | (s7_q & rx_sync_q) | (s8_q & rx_sync_q);
    if (tick) begin
      pre_d = {PRE_W{1'b0}};
      smp_d = smp_q + 4'd1;
    end else begin
      pre_d = pre_q + PRE_W'(1);
      smp_d = smp_q;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic perr_q;
  logic parity_err_q;
`endif

  // Receive FSM with synchroniser and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      pre_q       <= {PRE_W{1'b0}};
      smp_q       <= 4'd0;
      s7_q        <= 1'b1;
      s8_q        <= 1'b1;
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_int_q    <= 1'b0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q       <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= rs232_rx;
      rx_sync_q   <= rx_meta_q;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          pre_q <= {PRE_W{1'b0}};
          smp_q <= 4'd0;
          if (!rx_sync_q) begin
            state_q <= S_START;
          end
        end
        S_BREAK: begin
          pre_q <= {PRE_W{1'b0}};
          smp_q <= 4'd0;
          if (rx_sync_q) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          pre_q <= pre_d;
          smp_q <= smp_d;
          if (tick && (smp_q == 4'd7)) s7_q <= rx_sync_q;
          if (tick && (smp_q == 4'd8)) s8_q <= rx_sync_q;
          case (state_q)
            S_START: begin
              if (decide) begin
                if (maj) state_q <= S_IDLE;
                else     rx_int_q <= 1'b1;
              end else if (wrap) begin
                state_q <= S_DATA;
                idx_q   <= 3'd0;
              end
            end
            S_DATA: begin
              if (decide) begin
                shift_q[idx_q] <= maj;
              end else if (wrap) begin
                if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_q <= S_PARITY;
`else
                  state_q <= S_STOP;
`endif
                end else begin
                  idx_q <= idx_q + 3'd1;
                end
              end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
              if (decide) perr_q <= maj ^ (^shift_q);
              else if (wrap) state_q <= S_STOP;
            end
`endif
            // Stop bit is judged at its centre; a low stop bit means a break may follow.
            S_STOP: begin
              if (decide) begin
                rx_data_q   <= shift_q;
                rx_int_q    <= 1'b0;
                rx_done_q   <= 1'b1;
                frame_err_q <= ~maj;
`ifdef UART_RX_PARITY_EN
                parity_err_q <= perr_q;
`endif
                state_q <= maj ? S_IDLE : S_BREAK;
              end
            end
            default: state_q <= S_IDLE;
          endcase
        end
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_int    = rx_int_q;
  assign rx_done   = rx_done_q;
  assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_my_uart_rx16.sv
// Scoreboard bench for my_uart_rx16 at default parameters (DIV=27, 432 clk per bit).
module tb_my_uart_rx16;

  localparam int BIT = 432;
  localparam int RISE_LAT = 3 + 270;
`ifdef UART_RX_PARITY_EN
  localparam int DONE_LAT = 3 + 170 * 27;
`else
  localparam int DONE_LAT = 3 + 154 * 27;
`endif

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
    int         t_done;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rs232_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_int;
  logic       rx_done;
  logic       frame_err;
  logic       parity_err;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t done_q[$];
  int   rise_q[$];
  logic rx_int_prev = 1'b0;

  my_uart_rx16 dut (
    .clk        (clk),
    .rst        (rst),
    .rs232_rx   (rs232_rx),
    .rx_data    (rx_data),
    .rx_int     (rx_int),
    .rx_done    (rx_done),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds one bit on the line; optionally inverts it for 30 clk around sample 8.
  task automatic drive_bit(input logic b, input logic glitch);
    rs232_rx = b;
    if (glitch) begin
      idle(229);
      rs232_rx = ~b;
      idle(30);
      rs232_rx = b;
      idle(BIT - 259);
    end else begin
      idle(BIT);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit,
                            input int glitch_bit);
    exp_t e;
    e.data   = d;
    e.ferr   = ~stop_bit;
`ifdef UART_RX_PARITY_EN
    e.perr   = par_bit ^ (^d);
`else
    e.perr   = 1'b0;
`endif
    e.t_done = cyc + DONE_LAT;
    rise_q.push_back(cyc + RISE_LAT);
    done_q.push_back(e);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i], (i == glitch_bit));
`ifdef UART_RX_PARITY_EN
    drive_bit(par_bit, 1'b0);
`endif
    drive_bit(stop_bit, 1'b0);
  endtask

  // Output monitor: every rx_int rise and rx_done pulse must match a scoreboard entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_int && !rx_int_prev) begin
        if (rise_q.size() == 0) chk("rise_q_size", rise_q.size(), 1);
        else chk("rise_time", cyc, rise_q.pop_front());
      end
      if (rx_done) begin
        if (done_q.size() == 0) begin
          chk("done_q_size", done_q.size(), 1);
        end else begin
          exp_t e;
          e = done_q.pop_front();
          chk("rx_data", rx_data, e.data);
          chk("frame_err", frame_err, e.ferr);
          chk("parity_err", parity_err, e.perr);
          chk("done_time", cyc, e.t_done);
          chk("rx_int_fall", rx_int, 0);
        end
      end
      if ((frame_err || parity_err) && !rx_done)
        chk("err_without_done", {frame_err, parity_err}, 0);
    end
    rx_int_prev <= rx_int;
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(5);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_int", rx_int, 0);
    chk("rst_rx_done", rx_done, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_parity_err", parity_err, 0);
    rst = 1'b0;
    idle(100);

    send_frame(8'hA5, 1'b0, 1'b1, -1);
    idle(500);

    // False start: 100 clk low pulse must not start a frame.
    rs232_rx = 1'b0;
    idle(100);
    rs232_rx = 1'b1;
    idle(1000);

    // Stop bit low, line held low: one frame with frame_err, then break.
    send_frame(8'h3C, 1'b0, 1'b0, -1);
    idle(2000);
    rs232_rx = 1'b1;
    idle(500);

    send_frame(8'h00, 1'b0, 1'b1, -1);
    send_frame(8'hFF, 1'b0, 1'b1, -1);
    idle(500);

    send_frame(8'h55, 1'b0, 1'b1, 2);
    idle(500);

    // Aborted 0x81: reset in the middle of bit 4.
    rise_q.push_back(cyc + RISE_LAT);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    for (int i = 1; i < 4; i++) drive_bit(1'b0, 1'b0);
    rs232_rx = 1'b0;
    idle(BIT / 2);
    rst = 1'b1;
    rs232_rx = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("midrst_rx_data", rx_data, 8'h00);
    chk("midrst_rx_int", rx_int, 0);
    chk("midrst_rx_done", rx_done, 0);
    idle(1000);
    send_frame(8'h81, 1'b0, 1'b1, -1);
    idle(500);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, -1);
    idle(300);
    send_frame(8'h07, 1'b0, 1'b1, -1);
    idle(300);
`endif

    chk("pending_done", done_q.size(), 0);
    chk("pending_rise", rise_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
